// File: rtl/viterbi_ber_checker.sv
// Bit-error-rate checker for the encoder -> channel -> Viterbi loopback.
// Finds the end-to-end decoder lag by sweeping candidate lags against a
// history of source bits, then counts compared bits and bit errors while locked.
module viterbi_ber_checker #(
    parameter int unsigned MAX_LAT  = 64,
    parameter int unsigned WIN      = 32,
    parameter int unsigned LOSS_THR = 8,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           src_valid_i,
    input  logic                           src_bit_i,
    input  logic                           dec_bit_i,
    input  logic                           clear_i,
    output logic                           locked_o,
    output logic [$clog2(MAX_LAT+1)-1:0]   lat_o,
    output logic [CNT_W-1:0]               bit_cnt_o,
    output logic [CNT_W-1:0]               err_cnt_o,
    output logic                           err_pulse_o,
    output logic                           search_fail_o
);

    localparam int unsigned LAT_W = $clog2(MAX_LAT + 1);
    localparam int unsigned IDX_W = $clog2(MAX_LAT);
    localparam int unsigned MC_W  = $clog2(WIN + 1);
    localparam int unsigned BLK_W = $clog2(WIN);

    localparam logic [0:0] S_SEARCH = 1'b0;
    localparam logic [0:0] S_LOCKED = 1'b1;

    logic [0:0]         state, state_n;
    logic [MAX_LAT-1:0] hist_v;
    logic [MAX_LAT-1:0] hist_b;
    logic [LAT_W-1:0]   cand, cand_n;
    logic [MC_W-1:0]    match_cnt, match_cnt_n;
    logic [BLK_W-1:0]   blk_cnt, blk_cnt_n;
    logic [MC_W-1:0]    blk_err, blk_err_n;
    logic               locked_n;
    logic [LAT_W-1:0]   lat_n;
    logic [CNT_W-1:0]   bit_cnt_n, err_cnt_n;
    logic               err_pulse_n, search_fail_n;

    logic [IDX_W-1:0]   idx;
    logic               cmp_v, cmp_err;
    logic [MC_W-1:0]    blk_err_inc;

    // Lag search, lock tracking, block-based loss detection and counters
    always_comb begin
        state_n       = state;
        cand_n        = cand;
        match_cnt_n   = match_cnt;
        blk_cnt_n     = blk_cnt;
        blk_err_n     = blk_err;
        locked_n      = locked_o;
        lat_n         = lat_o;
        bit_cnt_n     = bit_cnt_o;
        err_cnt_n     = err_cnt_o;
        err_pulse_n   = 1'b0;
        search_fail_n = 1'b0;

        // cand tracks lat_o while locked, so one tap serves both states
        idx         = IDX_W'(cand - LAT_W'(1));
        cmp_v       = hist_v[idx];
        cmp_err     = hist_b[idx] ^ dec_bit_i;
        blk_err_inc = blk_err + MC_W'(cmp_err);

        case (state)
            S_SEARCH: begin
                if (cmp_v) begin
                    if (!cmp_err) begin
                        if (match_cnt == MC_W'(WIN - 1)) begin
                            state_n     = S_LOCKED;
                            locked_n    = 1'b1;
                            lat_n       = cand;
                            match_cnt_n = '0;
                            blk_cnt_n   = '0;
                            blk_err_n   = '0;
                        end else begin
                            match_cnt_n = match_cnt + MC_W'(1);
                        end
                    end else begin
                        match_cnt_n = '0;
                        if (cand == LAT_W'(MAX_LAT)) begin
                            cand_n        = LAT_W'(1);
                            search_fail_n = 1'b1;
                        end else begin
                            cand_n = cand + LAT_W'(1);
                        end
                    end
                end
            end
            S_LOCKED: begin
                if (cmp_v) begin
                    if (bit_cnt_o != {CNT_W{1'b1}}) begin
                        bit_cnt_n = bit_cnt_o + CNT_W'(1);
                    end
                    if (cmp_err) begin
                        err_pulse_n = 1'b1;
                        if (err_cnt_o != {CNT_W{1'b1}}) begin
                            err_cnt_n = err_cnt_o + CNT_W'(1);
                        end
                    end
                    if (blk_cnt == BLK_W'(WIN - 1)) begin
                        blk_cnt_n = '0;
                        blk_err_n = '0;
                        if (blk_err_inc > MC_W'(LOSS_THR)) begin
                            state_n     = S_SEARCH;
                            locked_n    = 1'b0;
                            cand_n      = LAT_W'(1);
                            match_cnt_n = '0;
                        end
                    end else begin
                        blk_cnt_n = blk_cnt + BLK_W'(1);
                        blk_err_n = blk_err_inc;
                    end
                end
            end
            default: begin
                state_n = S_SEARCH;
            end
        endcase

        // Clear beats any same-cycle increment
        if (clear_i) begin
            bit_cnt_n = '0;
            err_cnt_n = '0;
        end
    end

    // State, history and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_SEARCH;
            hist_v        <= '0;
            hist_b        <= '0;
            cand          <= LAT_W'(1);
            match_cnt     <= '0;
            blk_cnt       <= '0;
            blk_err       <= '0;
            locked_o      <= 1'b0;
            lat_o         <= '0;
            bit_cnt_o     <= '0;
            err_cnt_o     <= '0;
            err_pulse_o   <= 1'b0;
            search_fail_o <= 1'b0;
        end else begin
            state         <= state_n;
            hist_v        <= {hist_v[MAX_LAT-2:0], src_valid_i};
            hist_b        <= {hist_b[MAX_LAT-2:0], src_bit_i & src_valid_i};
            cand          <= cand_n;
            match_cnt     <= match_cnt_n;
            blk_cnt       <= blk_cnt_n;
            blk_err       <= blk_err_n;
            locked_o      <= locked_n;
            lat_o         <= lat_n;
            bit_cnt_o     <= bit_cnt_n;
            err_cnt_o     <= err_cnt_n;
            err_pulse_o   <= err_pulse_n;
            search_fail_o <= search_fail_n;
        end
    end

endmodule

// File: tb/tb_viterbi_ber_checker.sv
// Self-checking bench: PRBS7 source, decoder modelled as a delay line with
// optional bit inversion, err_pulse scoreboard, 16-bit and 4-bit counter DUTs.
module tb_viterbi_ber_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       src_valid_i = 1'b0;
    logic       src_bit_i = 1'b0;
    logic       dec_bit_i = 1'b0;
    logic       clear_i = 1'b0;

    logic        locked_o, err_pulse_o, search_fail_o;
    logic [6:0]  lat_o;
    logic [15:0] bit_cnt_o, err_cnt_o;

    logic        locked4, err_pulse4, search_fail4;
    logic [6:0]  lat4;
    logic [3:0]  bit_cnt4, err_cnt4;

    int tests = 0;
    int fails = 0;

    logic [127:0] tb_hist = '0;
    logic [6:0]   lfsr = 7'h7F;
    int           dly = 10;
    bit           tog_en = 1'b0;
    bit           sb_en = 1'b0;
    logic         sb_q[$];

    always #5 clk = ~clk;

    viterbi_ber_checker #(.MAX_LAT(64), .WIN(32), .LOSS_THR(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .src_valid_i(src_valid_i), .src_bit_i(src_bit_i),
        .dec_bit_i(dec_bit_i), .clear_i(clear_i), .locked_o(locked_o), .lat_o(lat_o),
        .bit_cnt_o(bit_cnt_o), .err_cnt_o(err_cnt_o), .err_pulse_o(err_pulse_o),
        .search_fail_o(search_fail_o)
    );

    viterbi_ber_checker #(.MAX_LAT(64), .WIN(32), .LOSS_THR(8), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .src_valid_i(src_valid_i), .src_bit_i(src_bit_i),
        .dec_bit_i(dec_bit_i), .clear_i(clear_i), .locked_o(locked4), .lat_o(lat4),
        .bit_cnt_o(bit_cnt4), .err_cnt_o(err_cnt4), .err_pulse_o(err_pulse4),
        .search_fail_o(search_fail4)
    );

    // One clock: shift channel model, check scoreboard, drive next cycle's inputs
    task automatic step(input logic inv, input logic clr);
        logic exp;
        @(posedge clk);
        tb_hist = {tb_hist[126:0], src_bit_i};
        #1;
        if (sb_q.size() > 0) begin
            exp = sb_q.pop_front();
            tests++;
            if (err_pulse_o !== exp) begin
                fails++;
                $display("FAIL err_pulse: got %0b expected %0b at %0t", err_pulse_o, exp, $time);
            end
        end
        clear_i = clr;
        src_valid_i = tog_en ? ~src_valid_i : 1'b1;
        if (src_valid_i) begin
            src_bit_i = lfsr[6];
            lfsr = {lfsr[5:0], lfsr[6] ^ lfsr[5]};
        end
        dec_bit_i = tb_hist[dly-1] ^ inv;
        if (sb_en) sb_q.push_back(inv);
    endtask

    task automatic wait_lock(input string name);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 520; i++) begin
            step(1'b0, 1'b0);
            if (locked_o === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL %s lock: locked_o never rose within 520 cycles", name);
        end
        tests++;
        if (lat_o !== 7'd10) begin
            fails++;
            $display("FAIL %s lat: got %0d expected 10", name, lat_o);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        tests++; if (locked_o !== 1'b0) begin fails++; $display("FAIL rst locked: got %0b expected 0", locked_o); end
        tests++; if (lat_o !== 7'd0) begin fails++; $display("FAIL rst lat: got %0d expected 0", lat_o); end
        tests++; if (bit_cnt_o !== 16'd0) begin fails++; $display("FAIL rst bit_cnt: got %0d expected 0", bit_cnt_o); end
        tests++; if (err_cnt_o !== 16'd0) begin fails++; $display("FAIL rst err_cnt: got %0d expected 0", err_cnt_o); end
        tests++; if (err_pulse_o !== 1'b0) begin fails++; $display("FAIL rst err_pulse: got %0b expected 0", err_pulse_o); end
        tests++; if (search_fail_o !== 1'b0) begin fails++; $display("FAIL rst search_fail: got %0b expected 0", search_fail_o); end
        rst = 1'b1;
    endtask

    task automatic test_lock_count();
        wait_lock("initial");
        for (int i = 0; i < 1000; i++) step(1'b0, 1'b0);
        tests++; if (bit_cnt_o !== 16'd1000) begin fails++; $display("FAIL count bit_cnt: got %0d expected 1000", bit_cnt_o); end
        tests++; if (err_cnt_o !== 16'd0) begin fails++; $display("FAIL count err_cnt: got %0d expected 0", err_cnt_o); end
        tests++; if (bit_cnt4 !== 4'd15) begin fails++; $display("FAIL count bit_cnt4 sat: got %0d expected 15", bit_cnt4); end
    endtask

    task automatic test_single_error();
        sb_en = 1'b1;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        sb_en = 1'b0;
        step(1'b0, 1'b0);
        tests++; if (err_cnt_o !== 16'd1) begin fails++; $display("FAIL single err_cnt: got %0d expected 1", err_cnt_o); end
        tests++; if (locked_o !== 1'b1) begin fails++; $display("FAIL single locked: got %0b expected 1", locked_o); end
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        tests++; if (bit_cnt_o !== 16'd0) begin fails++; $display("FAIL clear bit_cnt: got %0d expected 0", bit_cnt_o); end
        tests++; if (err_cnt_o !== 16'd0) begin fails++; $display("FAIL clear err_cnt: got %0d expected 0", err_cnt_o); end
        tests++; if (locked_o !== 1'b1) begin fails++; $display("FAIL clear locked: got %0b expected 1", locked_o); end
    endtask

    task automatic test_reset_and_loss();
        // asynchronous reset away from any clock edge
        rst = 1'b0;
        #2;
        tests++; if (locked_o !== 1'b0 || lat_o !== 7'd0) begin fails++; $display("FAIL async rst lock/lat: got %0b/%0d expected 0/0", locked_o, lat_o); end
        tests++; if (bit_cnt_o !== 16'd0 || err_cnt_o !== 16'd0) begin fails++; $display("FAIL async rst counts: got %0d/%0d expected 0/0", bit_cnt_o, err_cnt_o); end
        tests++; if (err_pulse_o !== 1'b0 || search_fail_o !== 1'b0) begin fails++; $display("FAIL async rst pulses: got %0b/%0b expected 0/0", err_pulse_o, search_fail_o); end
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        rst = 1'b1;
        wait_lock("post-reset");
        // counted compare #1 is already on the wires; next 9 inverted, then 22 clean
        sb_en = 1'b1;
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 22; i++) step(1'b0, 1'b0);
        tests++; if (locked_o !== 1'b1) begin fails++; $display("FAIL loss early: locked_o %0b expected 1 before block end", locked_o); end
        step(1'b0, 1'b0);
        sb_en = 1'b0;
        sb_q.delete();
        tests++; if (locked_o !== 1'b0) begin fails++; $display("FAIL loss: locked_o %0b expected 0 at block end", locked_o); end
        tests++; if (err_cnt_o !== 16'd9) begin fails++; $display("FAIL loss err_cnt: got %0d expected 9", err_cnt_o); end
        tests++; if (err_cnt4 !== 4'd9) begin fails++; $display("FAIL loss err_cnt4: got %0d expected 9", err_cnt4); end
        wait_lock("relock");
    endtask

    task automatic test_saturation();
        step(1'b0, 1'b1);
        for (int i = 0; i < 200; i++) step((i % 10) == 5, 1'b0);
        step(1'b0, 1'b0);
        tests++; if (bit_cnt_o !== 16'd200) begin fails++; $display("FAIL sat bit_cnt: got %0d expected 200", bit_cnt_o); end
        tests++; if (err_cnt_o !== 16'd20) begin fails++; $display("FAIL sat err_cnt: got %0d expected 20", err_cnt_o); end
        tests++; if (err_cnt4 !== 4'd15) begin fails++; $display("FAIL sat err_cnt4: got %0d expected 15", err_cnt4); end
        tests++; if (bit_cnt4 !== 4'd15) begin fails++; $display("FAIL sat bit_cnt4: got %0d expected 15", bit_cnt4); end
        tests++; if (locked_o !== 1'b1) begin fails++; $display("FAIL sat locked: got %0b expected 1", locked_o); end
    endtask

    task automatic test_valid_toggle();
        tog_en = 1'b1;
        do_reset();
        wait_lock("toggle");
        for (int i = 0; i < 100; i++) step(1'b0, 1'b0);
        tests++; if (bit_cnt_o !== 16'd50) begin fails++; $display("FAIL toggle bit_cnt: got %0d expected 50", bit_cnt_o); end
        tests++; if (err_cnt_o !== 16'd0) begin fails++; $display("FAIL toggle err_cnt: got %0d expected 0", err_cnt_o); end
        tog_en = 1'b0;
    endtask

    task automatic test_no_lock();
        int last;
        int npulse;
        bit seen_lock;
        dly = 80;
        do_reset();
        last = -1;
        npulse = 0;
        seen_lock = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            step(1'b0, 1'b0);
            if (locked_o !== 1'b0) seen_lock = 1'b1;
            if (search_fail_o === 1'b1) begin
                if (last >= 0) begin
                    tests++;
                    if ((i - last) < 64 || (i - last) > 600) begin
                        fails++;
                        $display("FAIL sweep gap: got %0d cycles expected 64..600", i - last);
                    end
                end
                last = i;
                npulse++;
            end
        end
        tests++; if (seen_lock) begin fails++; $display("FAIL nolock: locked_o rose with out-of-range lag"); end
        tests++; if (npulse < 2) begin fails++; $display("FAIL nolock pulses: got %0d expected >= 2", npulse); end
        tests++; if (err_cnt_o !== 16'd0) begin fails++; $display("FAIL nolock err_cnt: got %0d expected 0", err_cnt_o); end
        dly = 10;
    endtask

    initial begin
        test_reset();
        test_lock_count();
        test_single_error();
        test_reset_and_loss();
        test_saturation();
        test_valid_toggle();
        test_no_lock();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/viterbi_ber_checker.md
# viterbi_ber_checker

Bit-error-rate checker downstream of the Viterbi decoder in the encoder → channel → decoder loopback. It keeps a history of the source bits fed to the convolutional encoder and finds the decoder's end-to-end latency automatically. It then compares every decoded bit against the matching source bit and reports bit and error counts, per-error pulses and lock status, giving benches and boards a BER figure without hand-tuned delay matching.

## Interface
- MAX_LAT, 64: largest end-to-end lag (cycles) searched; lag range 1..MAX_LAT
- WIN, 32: consecutive valid matches needed to declare lock; also the loss-check block length
- LOSS_THR, 8: block error count above which lock is dropped
- CNT_W, 16: width of bit/error counters
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  asynchronous active-low reset
- src_valid_i  input  1  source bit valid (encoder enable)
- src_bit_i  input  1  source bit (encoder data input)
- dec_bit_i  input  1  decoder output bit, sampled every cycle
- clear_i  input  1  synchronous clear of bit/error counters
- locked_o  output  1  latency found, compares counting
- lat_o  output  $clog2(MAX_LAT+1)  locked lag (cycles)
- bit_cnt_o  output  CNT_W  compared bits since reset/clear, saturating
- err_cnt_o  output  CNT_W  mismatched bits since reset/clear, saturating
- err_pulse_o  output  1  one-cycle pulse per mismatch while locked
- search_fail_o  output  1  one-cycle pulse when a full lag sweep wraps

## Operation
- History: MAX_LAT-deep shift register of {valid, bit}, shifted every cycle; stores {src_valid_i, src_bit_i & src_valid_i}. Lag L compares dec_bit_i at cycle t with src_bit_i at cycle t-L (entry L-1). Compares happen only when that entry's valid = 1; invalid cycles affect no counter or window.
- States:
  - SEARCH: reset state. cand = 1, match_cnt = 0.
  - LOCKED: entered from SEARCH.
- SEARCH behaviour:
  - Valid match: match_cnt++.
  - Valid mismatch: cand++ and match_cnt = 0.
  - cand = MAX_LAT with a mismatch: cand wraps to 1 and search_fail_o pulses.
  - match_cnt reaching WIN: go to LOCKED, lat_o = cand.
- LOCKED behaviour:
  - Each valid compare: bit_cnt++.
  - Each valid mismatch: err_cnt++ and err_pulse_o pulses.
  - A block counter (0..WIN-1) tracks valid compares, with blk_err counting errors inside the block.
  - At block end, blk_err > LOSS_THR: go to SEARCH with cand = 1, locked_o = 0, lat_o held. Otherwise blk_err is reset and the block counter restarts.
- Counters saturate at all-ones. bit_cnt and err_cnt saturate independently.
- clear_i zeroes bit_cnt and err_cnt on the next edge and wins over a same-cycle increment; that compare is discarded. clear_i does not touch state, lat_o or the lock windows.
- In SEARCH, bit_cnt, err_cnt and err_pulse_o do not update. The counters hold their values across lock loss.

## Timing
- Reset (async, any state): state = SEARCH, history cleared to invalid.
  - All outputs 0: locked_o, lat_o, bit_cnt_o, err_cnt_o, err_pulse_o, search_fail_o.
  - Internal cand = 1, match_cnt = 0, blk_err = 0.
- All outputs are registered. Effects appear on the edge after the sampled compare cycle.
- locked_o rises on the edge ending the WIN-th consecutive valid match.
- The first counted compare is the next valid cycle after locked_o rises.
- err_pulse_o is high for exactly one cycle per mismatch. Back-to-back mismatches give a continuous high.
- Lag changes in SEARCH take effect on the next cycle. No compare is skipped beyond the mismatching one.
- Lock loss: locked_o falls on the edge ending the failing block.
- Reset asserted mid-operation: outputs go to reset values immediately. After release, the checker re-searches from cand = 1, ignoring history taken before reset.

## Test plan
- Decoder modelled as a 10-cycle delay of src_bit_i; PRBS7 source, src_valid_i = 1 continuously → locked_o = 1 and lat_o = 10 within 10·WIN + 200 cycles; after 1000 further cycles bit_cnt_o = 1000 and err_cnt_o = 0.
- Same setup, locked, one decoded bit inverted → err_pulse_o high exactly 1 cycle, err_cnt_o = 1, locked_o stays 1. Then clear_i for 1 cycle → both counters 0 on the next edge.
- Locked, 9 inverted bits inside one 32-compare block → locked_o falls at block end, err_cnt_o = 9, re-lock at lat_o = 10.
- Delay model 80 cycles (> MAX_LAT) → locked_o never rises, and search_fail_o pulses at least once every sweep.
- src_valid_i toggled 1/0 every cycle with lag 10 → lock still achieved, and bit_cnt_o advances by 1 per valid source bit only.
- CNT_W = 4 with 20 forced errors → err_cnt_o sticks at 15 and bit_cnt_o sticks at 15. Async reset pulse mid-lock → all outputs 0 immediately, then re-lock at lag 10.
